// File: rtl/imem_pkg.sv
// imem_loader shared types and constants.
// Loader FSM state encoding plus image framing sizes.
package imem_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word packer for the imem loader.
// Flags word_complete on the 4th accepted byte of a group.
module imem_loader_byte_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  in_data,
  output logic [31:0] word_next,
  output logic        word_complete
);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] word_q, word_d;

  // next word/index; only the low three bytes need storing
  always_comb begin
    word_next     = {word_q, in_data};
    word_complete = shift_en &&
                    (idx_q == 2'(BYTES_PER_WORD - 1));
    idx_d         = idx_q;
    word_d        = word_q;
    if (clr) begin
      idx_d  = '0;
      word_d = '0;
    end else if (shift_en) begin
      idx_d  = idx_q + 2'd1;
      word_d = word_next[23:0];
    end
  end

  // shift register and byte counter
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader: byte stream to word writes.
// Holds the core in reset while a program image loads.
module imem_loader
  import imem_pkg::*;
#(
  parameter int          DEPTH     = 100,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_hold,
  output logic [15:0] words_written
);

  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  state_e      state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [15:0] ww_q, ww_d;
  logic        in_ready_q, in_ready_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wd_q, mem_wd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        accept;
  logic        pk_clr;
  logic        pk_shift;
  logic [31:0] word_next;
  logic        word_complete;
  logic [15:0] n_full;

  assign accept   = in_valid && in_ready_q;
  assign pk_shift = accept && (state_q == S_DATA);
  assign n_full   = {n_q[15:8], in_data};

  imem_loader_byte_packer u_packer (
    .clk           (clk),
    .rst           (rst),
    .clr           (pk_clr),
    .shift_en      (pk_shift),
    .in_data       (in_data),
    .word_next     (word_next),
    .word_complete (word_complete)
  );

  // next state, counters and write-port values
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    ww_d       = ww_q;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
    pk_clr     = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_HI;
          ww_d    = '0;
          pk_clr  = 1'b1;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          n_d[15:8] = in_data;
          state_d   = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          n_d    = n_full;
          pk_clr = 1'b1;
          if (n_full == 16'd0)
            state_d = S_DONE;
          else if (n_full > DEPTH16)
            state_d = S_ERR;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (word_complete) begin
          state_d    = S_WRITE;
          mem_addr_d = BASE_ADDR +
                       {14'd0, ww_q, 2'b00};
          mem_wd_d   = word_next;
        end
      end
      S_WRITE: begin
        ww_d    = ww_q + 16'd1;
        state_d = (ww_d == n_q) ? S_DONE : S_DATA;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // registered status outputs decoded from next state
  always_comb begin
    in_ready_d = 1'b0;
    busy_d     = 1'b0;
    mem_we_d   = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (1'b1)
      state_d == S_LEN_HI,
      state_d == S_LEN_LO,
      state_d == S_DATA: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b1;
      end
      state_d == S_WRITE: begin
        busy_d   = 1'b1;
        mem_we_d = 1'b1;
      end
      state_d == S_DONE: done_d = 1'b1;
      state_d == S_ERR:  err_d  = 1'b1;
      default: ;
    endcase
  end

  // loader FSM and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      ww_q       <= '0;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      ww_q       <= ww_d;
      in_ready_q <= in_ready_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wd        = mem_wd_q;
  assign busy          = busy_q;
  assign cpu_hold      = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign words_written = ww_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader.
// Checks writes, status flags, stalls and length edge cases.
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_hold;
  logic [15:0] words_written;

  int checks = 0;
  int errors = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [7:0]  img[$];

  imem_loader #(
    .DEPTH     (100),
    .BASE_ADDR (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wd        (mem_wd),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .cpu_hold      (cpu_hold),
    .words_written (words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // record every memory write
  always @(negedge clk) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wd);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h",
               tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input int stall);
    bit got;
    got = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (!got) check("accept_timeout", 0, 1);
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_img(input int stall, input int limit);
    for (int i = 0; i < img.size() && i < limit; i++)
      send_byte(img[i], stall);
  endtask

  task automatic wait_end();
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done || err) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) check("end_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic basic_img();
    img = '{8'h00, 8'h02,
            8'h20, 8'h08, 8'h00, 8'h05,
            8'h20, 8'h09, 8'h00, 8'h07};
  endtask

  function automatic logic [31:0] qa(input int k);
    return (k < wa.size()) ? wa[k] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] qd(input int k);
    return (k < wd.size()) ? wd[k] : 32'hxxxx_xxxx;
  endfunction

  task automatic check_two_writes(input string pfx);
    check({pfx, "_nwr"}, wa.size(), 2);
    check({pfx, "_a0"}, qa(0), 32'h0);
    check({pfx, "_d0"}, qd(0), 32'h2008_0005);
    check({pfx, "_a1"}, qa(1), 32'h4);
    check({pfx, "_d1"}, qd(1), 32'h2009_0007);
    check({pfx, "_done"}, done, 1);
    check({pfx, "_ww"}, words_written, 2);
    check({pfx, "_hold"}, cpu_hold, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_we", mem_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wd", mem_wd, 0);
    check("rst_ww", words_written, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // basic back-to-back load
    wa.delete(); wd.delete();
    basic_img();
    do_start();
    check("b_busy", busy, 1);
    check("b_hold", cpu_hold, 1);
    send_img(0, 1000);
    wait_end();
    check_two_writes("basic");

    // stalled stream
    wa.delete(); wd.delete();
    do_start();
    check("s_done_clr", done, 0);
    send_img(3, 1000);
    wait_end();
    check_two_writes("stall");

    // zero length
    wa.delete(); wd.delete();
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("z_done", done, 1);
    check("z_busy", busy, 0);
    check("z_ww", words_written, 0);
    check("z_nwr", wa.size(), 0);

    // length error, 101 > DEPTH
    wa.delete(); wd.delete();
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h65, 0);
    @(negedge clk);
    check("e_err", err, 1);
    check("e_done", done, 0);
    check("e_ready", in_ready, 0);
    check("e_busy", busy, 0);
    check("e_nwr", wa.size(), 0);
    @(posedge clk);
    #1;

    // full depth, word k = k
    wa.delete(); wd.delete();
    img = '{8'h00, 8'h64};
    for (int k = 0; k < 100; k++) begin
      img.push_back(8'h00);
      img.push_back(8'h00);
      img.push_back(8'h00);
      img.push_back(8'(k));
    end
    do_start();
    check("f_err_clr", err, 0);
    check("f_busy", busy, 1);
    send_img(0, 1000);
    wait_end();
    check("f_nwr", wa.size(), 100);
    check("f_a50", qa(50), 32'hC8);
    check("f_d50", qd(50), 32'h32);
    check("f_alast", qa(99), 32'h18C);
    check("f_dlast", qd(99), 32'h63);
    check("f_done", done, 1);
    check("f_err", err, 0);
    check("f_ww", words_written, 100);

    // reset after 6 data bytes
    wa.delete(); wd.delete();
    basic_img();
    do_start();
    send_img(0, 8);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("r_nwr", wa.size(), 1);
    check("r_d0", qd(0), 32'h2008_0005);
    check("r_ready", in_ready, 0);
    check("r_we", mem_we, 0);
    check("r_busy", busy, 0);
    check("r_hold", cpu_hold, 0);
    check("r_done", done, 0);
    check("r_err", err, 0);
    check("r_addr", mem_addr, 0);
    check("r_wd", mem_wd, 0);
    check("r_ww", words_written, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("r_idle_busy", busy, 0);
    check("r_idle_ready", in_ready, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the instruction memory: it loads a program image into a writable instruction RAM before the MIPS core runs. It accepts a byte stream on a valid/ready handshake and packs the bytes big-endian into 32-bit words. It issues one word write per instruction on a memory write port that uses byte addressing, and it holds the core in reset while loading. It sits between the host/debug byte link and the instruction RAM write port, and its addresses index the same memory the core fetches from with A>>2.

Parameters:
DEPTH, 100, number of 32-bit words in instruction memory
BASE_ADDR, 32'h0000_0000, byte address of the first written word (word-aligned)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse that begins a load; sampled only in IDLE, DONE or ERR
in_valid  input  1  byte on in_data is valid
in_data  input  8  stream byte
in_ready  output  1  loader accepts a byte this cycle
mem_we  output  1  instruction memory write enable, one cycle per word
mem_addr  output  32  byte address of the write, word-aligned
mem_wd  output  32  write data
busy  output  1  load in progress
done  output  1  load completed; held until next start
err  output  1  length error; held until next start
cpu_hold  output  1  keep the core in reset; equals busy
words_written  output  16  count of words written in current/last load

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; in_ready, mem_we, busy, done, err and cpu_hold are 0; mem_addr, mem_wd and words_written are 0. Reset mid-load aborts the load. Words already written stay in memory.
- Byte transfer occurs when in_valid && in_ready at a posedge. in_ready is a registered output; it depends on state only, never on in_valid.
- Image format: 2-byte word count N (MSB first), then N*4 data bytes. The first byte of each group is instruction bits [31:24].
- States:
  IDLE: in_ready=0. On start: clear done, err and words_written, go to LEN_HI.
  LEN_HI: in_ready=1. On accept: N[15:8]<=in_data, go to LEN_LO.
  LEN_LO: in_ready=1. On accept: N[7:0]<=in_data. If N==0, go to DONE. If N>DEPTH, go to ERR. Otherwise clear byte_idx, go to DATA.
  DATA: in_ready=1. On accept: word<={word[23:0],in_data}, byte_idx++. On the 4th byte (byte_idx==3), go to WRITE.
  WRITE: in_ready=0. mem_we=1 for exactly this cycle, mem_addr=BASE_ADDR+(words_written<<2), mem_wd=word. Next cycle: words_written++. If the new count equals N, go to DONE; otherwise go to DATA.
  DONE: done=1, busy=0. On start, restart as from IDLE.
  ERR: err=1, busy=0, no writes performed. On start, restart as from IDLE.
- busy=1 and cpu_hold=1 in LEN_HI, LEN_LO, DATA and WRITE. start is ignored while busy.
- Latency: mem_we asserts the cycle after the 4th byte of a word is accepted. Peak rate is 4 bytes per 5 cycles.
- mem_we=0 in every state except WRITE. mem_addr and mem_wd hold their last values outside WRITE.
- in_valid gaps (stalls) in any accepting state: state and partial word are preserved indefinitely.
- N==DEPTH is legal. The last address is BASE_ADDR+4*(DEPTH-1).
- Address arithmetic is 32-bit unsigned; the range check guarantees no wrap for legal N.

Decomposition:
- Package imem_pkg holds:
  - state encoding (IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR);
  - BYTES_PER_WORD=4;
  - LEN_BYTES=2.
- One natural sub-module, byte_packer: a 4-byte shift register with byte_idx counter, which flags word_complete on the 4th accepted byte and clears on start or rst.

Test Plan:
- Basic load: start, stream 00 02 | 20 08 00 05 | 20 09 00 07, in_valid always high. Require two writes: (addr 0x0, wd 0x20080005) then (0x4, 0x20090007). Then done=1, words_written=2, cpu_hold=0.
- Stalled stream: same image with in_valid low 3 cycles between every byte. Require identical writes, no extra mem_we, and partial words intact.
- Zero length: N=00 00. Require DONE two accepts after start, no mem_we, words_written=0.
- Length error: N=00 65 (101) with DEPTH=100. Require err=1, done=0, no mem_we, in_ready=0 afterwards. A following legal start clears err.
- Full depth: N=100, data word k = k. Require last write at addr 0x18C with wd 0x63, then done.
- Reset mid-load: rst asserted after 6 data bytes. Require 1 write completed, all outputs at reset values next cycle, start ignored while rst=1.
